// File: rtl/branch_cond_unit_if.sv
// branch_cond_unit_if: flag/loop-counter inputs and eval/decision handshakes of branch_cond_unit
interface branch_cond_unit_if #(parameter int DATA_WIDTH = 8);
  logic                  flag_we;
  logic [DATA_WIDTH-1:0] result;
  logic                  carry_in;
  logic                  ovf_in;
  logic                  lc_load;
  logic [DATA_WIDTH-1:0] lc_din;
  logic                  eval_valid;
  logic                  eval_ready;
  logic [3:0]            cond;
  logic                  taken_valid;
  logic                  taken;
  logic                  taken_ready;
  logic [3:0]            flags;
  logic [DATA_WIDTH-1:0] lc;
  modport master (
    output flag_we, result, carry_in, ovf_in, lc_load, lc_din, eval_valid, cond, taken_ready,
    input  eval_ready, taken_valid, taken, flags, lc
  );
  modport slave (
    input  flag_we, result, carry_in, ovf_in, lc_load, lc_din, eval_valid, cond, taken_ready,
    output eval_ready, taken_valid, taken, flags, lc
  );
endinterface

// File: rtl/branch_cond_unit.sv
// branch_cond_unit: latches ALU flags, evaluates condition codes, owns the loop counter.
// Define COND_FLAG_BYPASS_EN to forward same-cycle flag writes into the evaluation.
module branch_cond_unit #(parameter int DATA_WIDTH = 8) (
  input logic clk,
  input logic rst,
  branch_cond_unit_if.slave bus
);
  logic [3:0]  new_flags, f;
  logic [15:0] tbl;
  logic        accept, lc_nz, z, n, c, v;
  assign new_flags = {bus.ovf_in, bus.carry_in, bus.result[DATA_WIDTH-1], bus.result == '0};
`ifdef COND_FLAG_BYPASS_EN
  assign f = bus.flag_we ? new_flags : bus.flags;
`else
  assign f = bus.flags;
`endif
  assign {v, c, n, z} = f;
  assign lc_nz = bus.lc != '0;
  // bit index equals condition code
  assign tbl = {lc_nz, c & ~z, ~(n ^ v), n ^ v, ~v, v, ~c, c,
                ~n & ~z, ~n, ~z, 1'b1, n | z, n, z, 1'b0};
  assign bus.eval_ready = ~bus.taken_valid | bus.taken_ready;
  assign accept = bus.eval_valid & bus.eval_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.flags       <= '0;
      bus.lc          <= '0;
      bus.taken       <= 1'b0;
      bus.taken_valid <= 1'b0;
    end else begin
      if (bus.flag_we) bus.flags <= new_flags;
      if (bus.lc_load) bus.lc <= bus.lc_din;
      else if (accept && bus.cond == 4'd15 && lc_nz) bus.lc <= bus.lc - 1'b1;
      if (accept) begin
        bus.taken       <= tbl[bus.cond];
        bus.taken_valid <= 1'b1;
      end else if (bus.taken_ready) bus.taken_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_branch_cond_unit.sv
// tb_branch_cond_unit: directed self-checking bench for branch_cond_unit
module tb_branch_cond_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fails = 0;
  branch_cond_unit_if #(.DATA_WIDTH(8)) bus ();
  branch_cond_unit #(.DATA_WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // expected taken for codes 0..14 with V=1 C=0 N=1 Z=0
  logic exp_tbl [15] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0};
  logic exp_loop [4] = '{1, 1, 1, 0};
  logic [7:0] exp_lc [4] = '{2, 1, 0, 0};
  initial begin
    rst = 1'b1;
    bus.flag_we = 0; bus.result = 0; bus.carry_in = 0; bus.ovf_in = 0;
    bus.lc_load = 0; bus.lc_din = 0; bus.eval_valid = 0; bus.cond = 0; bus.taken_ready = 1;
    step(); step();
    rst = 1'b0;
    check("rst_flags", 32'(bus.flags), 0);
    check("rst_lc", 32'(bus.lc), 0);
    check("rst_taken", 32'(bus.taken), 0);
    check("rst_taken_valid", 32'(bus.taken_valid), 0);
    check("rst_eval_ready", 32'(bus.eval_ready), 1);
    bus.flag_we = 1; bus.result = 8'h00;
    step();
    bus.flag_we = 0;
    check("z_flags", 32'(bus.flags), 4'b0001);
    bus.eval_valid = 1; bus.cond = 1;
    step();
    check("cond1_valid", 32'(bus.taken_valid), 1);
    check("cond1_taken", 32'(bus.taken), 1);
    bus.cond = 5;
    step();
    check("cond5_taken", 32'(bus.taken), 0);
    bus.eval_valid = 0;
    step();
    check("drain_valid", 32'(bus.taken_valid), 0);
    bus.flag_we = 1; bus.result = 8'h80; bus.carry_in = 0; bus.ovf_in = 1;
    step();
    bus.flag_we = 0;
    check("nv_flags", 32'(bus.flags), 4'b1010);
    bus.eval_valid = 1;
    for (int i = 0; i < 15; i++) begin
      bus.cond = 4'(i);
      step();
      check($sformatf("cond%0d_taken", i), 32'(bus.taken), 32'(exp_tbl[i]));
    end
    bus.eval_valid = 0; bus.lc_load = 1; bus.lc_din = 3;
    step();
    bus.lc_load = 0;
    check("lc_load", 32'(bus.lc), 3);
    bus.eval_valid = 1; bus.cond = 15;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("loop%0d_taken", i), 32'(bus.taken), 32'(exp_loop[i]));
      check($sformatf("loop%0d_lc", i), 32'(bus.lc), 32'(exp_lc[i]));
    end
    bus.eval_valid = 0; bus.lc_load = 1; bus.lc_din = 2;
    step();
    bus.eval_valid = 1; bus.cond = 15; bus.lc_din = 7;
    step();
    bus.eval_valid = 0; bus.lc_load = 0;
    check("loop_load_taken", 32'(bus.taken), 1);
    check("loop_load_lc", 32'(bus.lc), 7);
    step();
    bus.eval_valid = 1; bus.cond = 4; bus.taken_ready = 0;
    step();
    check("bp_first_taken", 32'(bus.taken), 1);
    bus.cond = 0;
    #1;
    check("bp_ready_low", 32'(bus.eval_ready), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("bp_hold%0d_taken", i), 32'(bus.taken), 1);
      check($sformatf("bp_hold%0d_valid", i), 32'(bus.taken_valid), 1);
    end
    bus.taken_ready = 1;
    #1;
    check("bp_ready_high", 32'(bus.eval_ready), 1);
    step();
    bus.eval_valid = 0;
    check("bp_second_taken", 32'(bus.taken), 0);
    check("bp_second_valid", 32'(bus.taken_valid), 1);
    step();
    check("bp_drain", 32'(bus.taken_valid), 0);
    bus.flag_we = 1; bus.result = 8'h05; bus.carry_in = 0; bus.ovf_in = 0;
    step();
    check("nz_flags", 32'(bus.flags), 0);
    bus.result = 8'h00; bus.eval_valid = 1; bus.cond = 1;
    step();
    bus.flag_we = 0; bus.eval_valid = 0;
`ifdef COND_FLAG_BYPASS_EN
    check("bypass_taken", 32'(bus.taken), 1);
`else
    check("bypass_taken", 32'(bus.taken), 0);
`endif
    check("bypass_flags", 32'(bus.flags), 4'b0001);
    bus.lc_load = 1; bus.lc_din = 5;
    step();
    bus.lc_load = 0; bus.eval_valid = 1; bus.cond = 4; bus.taken_ready = 0;
    step();
    check("pre_rst_valid", 32'(bus.taken_valid), 1);
    check("pre_rst_lc", 32'(bus.lc), 5);
    rst = 1; bus.eval_valid = 0;
    step();
    rst = 0;
    check("mid_rst_valid", 32'(bus.taken_valid), 0);
    check("mid_rst_lc", 32'(bus.lc), 0);
    check("mid_rst_flags", 32'(bus.flags), 0);
    bus.eval_valid = 1; bus.cond = 4; bus.taken_ready = 1;
    step();
    bus.eval_valid = 0;
    check("post_rst_taken", 32'(bus.taken), 1);
    check("post_rst_valid", 32'(bus.taken_valid), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
